// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle between the core datapath (master) and hazard_unit_mc (slave):
// register indices and stage flags in, stall/flush/forward controls and perf counters out.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E;
  logic [REG_AW-1:0] RdE, RdM, RdW;
  logic              PCSrcE;
  logic              ResultSrcE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              McStartE;

  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              McDoneE;
  logic [CNT_W-1:0]  LwStallCnt, McStallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output PCSrcE, ResultSrcE, RegWriteM, RegWriteW, McStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McDoneE,
    input  LwStallCnt, McStallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  PCSrcE, ResultSrcE, RegWriteM, RegWriteW, McStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McDoneE,
    output LwStallCnt, McStallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: EX forwarding, load-use/branch hazards and multi-cycle E-stage stall FSM.
// Latency: controls are combinational (0-cycle); a multi-cycle op stalls F/D/E for MC_CYCLES-1 cycles.
// Backpressure: held E op stalls F/D/E and bubbles M; HAZ_PERF_CNT_EN enables saturating perf counters.
module hazard_unit_mc #(
  parameter int REG_AW    = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_mc_if.slave hz
);

  localparam int CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (MC_CYCLES >= 3) ? CW'(MC_CYCLES - 3) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mcState_t;

  mcState_t        mcState;
  logic [CW-1:0]   cnt;
  logic            lwStall;
  logic            mcStall;
  logic            mcDone;

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic [REG_AW-1:0] rdW,
    input logic              regWriteM,
    input logic              regWriteW
  );
    logic [1:0] sel;
    sel = 2'b00;
    // M is the younger producer, so it takes priority over W
    if (rs != '0 && regWriteM && rs == rdM) begin
      sel = 2'b10;
    end else if (rs != '0 && regWriteW && rs == rdW) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
  end

  always_comb begin
    lwStall = hz.ResultSrcE && (hz.RdE != '0) &&
              ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
  end

  // cnt only matters in BUSY; it counts the remaining stall cycles after the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      mcState <= IDLE;
      cnt     <= '0;
    end else begin
      case (mcState)
        IDLE: begin
          if (hz.McStartE) begin
            if (MC_CYCLES == 2) begin
              mcState <= DONE;
            end else begin
              mcState <= BUSY;
              cnt     <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (!hz.McStartE) begin
            mcState <= IDLE;
          end else if (cnt == '0) begin
            mcState <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          mcState <= IDLE;
        end
        default: begin
          mcState <= IDLE;
        end
      endcase
    end
  end

  // In DONE the op is still presented but must not retrigger; dropping McStartE kills the op
  always_comb begin
    mcStall = hz.McStartE && (mcState != DONE);
    mcDone  = hz.McStartE && (mcState == DONE);
  end

  always_comb begin
    hz.StallF  = lwStall | mcStall;
    hz.StallD  = lwStall | mcStall;
    hz.StallE  = mcStall;
    hz.FlushD  = hz.PCSrcE & ~mcStall;
    hz.FlushE  = (lwStall | hz.PCSrcE) & ~mcStall;
    hz.FlushM  = mcStall;
    hz.McDoneE = mcDone;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] lwCnt, mcCnt, flCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lwCnt <= '0;
      mcCnt <= '0;
      flCnt <= '0;
    end else begin
      if (lwStall && lwCnt != '1) begin
        lwCnt <= lwCnt + 1'b1;
      end
      if (mcStall && mcCnt != '1) begin
        mcCnt <= mcCnt + 1'b1;
      end
      if (hz.FlushD && flCnt != '1) begin
        flCnt <= flCnt + 1'b1;
      end
    end
  end

  assign hz.LwStallCnt = lwCnt;
  assign hz.McStallCnt = mcCnt;
  assign hz.FlushCnt   = flCnt;
`else
  assign hz.LwStallCnt = '0;
  assign hz.McStallCnt = '0;
  assign hz.FlushCnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: MC_CYCLES=4/CNT_W=32 and MC_CYCLES=2/CNT_W=3 instances share stimulus.
// Directed vector table, hand-written multi-cycle/reset sequences, then random traffic vs a reference model.
module tb_hazard_unit_mc;

  typedef struct {
    logic [1:0] fa, fb;
    logic sF, sD, sE, fD, fE, fM, done;
    logic lw, mcs;
  } exp_t;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic pc, ld, wM, wW;
    logic [1:0] fa, fb;
    logic sF, fD, fE;
  } vec_t;

  logic clk, reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic pcSrcE, resultSrcE, regWriteM, regWriteW, mcStartE;

  hazard_unit_mc_if #(.REG_AW(5), .CNT_W(32)) if4();
  hazard_unit_mc_if #(.REG_AW(5), .CNT_W(3))  if2();

  assign if4.Rs1D = rs1D;  assign if2.Rs1D = rs1D;
  assign if4.Rs2D = rs2D;  assign if2.Rs2D = rs2D;
  assign if4.Rs1E = rs1E;  assign if2.Rs1E = rs1E;
  assign if4.Rs2E = rs2E;  assign if2.Rs2E = rs2E;
  assign if4.RdE  = rdE;   assign if2.RdE  = rdE;
  assign if4.RdM  = rdM;   assign if2.RdM  = rdM;
  assign if4.RdW  = rdW;   assign if2.RdW  = rdW;
  assign if4.PCSrcE     = pcSrcE;     assign if2.PCSrcE     = pcSrcE;
  assign if4.ResultSrcE = resultSrcE; assign if2.ResultSrcE = resultSrcE;
  assign if4.RegWriteM  = regWriteM;  assign if2.RegWriteM  = regWriteM;
  assign if4.RegWriteW  = regWriteW;  assign if2.RegWriteW  = regWriteW;
  assign if4.McStartE   = mcStartE;   assign if2.McStartE   = mcStartE;

  hazard_unit_mc #(.REG_AW(5), .MC_CYCLES(4), .CNT_W(32)) dut4 (.clk(clk), .reset(reset), .hz(if4));
  hazard_unit_mc #(.REG_AW(5), .MC_CYCLES(2), .CNT_W(3))  dut2 (.clk(clk), .reset(reset), .hz(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference state: position of the current op within its E-stage occupancy, and event tallies
  int pos4 = 0, pos2 = 0;
  longint cnt4[3], cnt2[3];
  exp_t a4, a2;
  longint ac4[3], ac2[3];

  vec_t tbl[10];
  bit st4[5] = '{1, 1, 1, 0, 0};
  bit dn4[5] = '{0, 0, 0, 1, 0};
  bit st2[5] = '{1, 0, 1, 0, 0};
  bit dn2[5] = '{0, 1, 0, 1, 0};

  task automatic chk(input string nm, input longint act, input longint exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] dM, input logic [4:0] dW,
                                     input logic wM, input logic wW);
    if (rs != 0 && wM && rs == dM) return 2'b10;
    if (rs != 0 && wW && rs == dW) return 2'b01;
    return 2'b00;
  endfunction

  // An op held in E for positions 1..mc: stalls before position mc, finishes at position mc
  function automatic exp_t model(input int mc, input int prev, output int posNow);
    exp_t e;
    posNow = !mcStartE ? 0 : ((prev >= mc) ? 1 : prev + 1);
    e.mcs  = mcStartE && (posNow < mc);
    e.done = (posNow == mc);
    e.lw   = resultSrcE && rdE != 0 && (rs1D == rdE || rs2D == rdE);
    e.fa   = fwd(rs1E, rdM, rdW, regWriteM, regWriteW);
    e.fb   = fwd(rs2E, rdM, rdW, regWriteM, regWriteW);
    e.sF   = e.lw | e.mcs;
    e.sD   = e.lw | e.mcs;
    e.sE   = e.mcs;
    e.fD   = pcSrcE & ~e.mcs;
    e.fE   = (e.lw | pcSrcE) & ~e.mcs;
    e.fM   = e.mcs;
    return e;
  endfunction

  function automatic longint cntExp(input longint v);
`ifdef HAZ_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic cmpExp(input string tag, input exp_t a, input exp_t e);
    chk({tag, " ForwardAE"}, a.fa, e.fa);
    chk({tag, " ForwardBE"}, a.fb, e.fb);
    chk({tag, " StallF"}, a.sF, e.sF);
    chk({tag, " StallD"}, a.sD, e.sD);
    chk({tag, " StallE"}, a.sE, e.sE);
    chk({tag, " FlushD"}, a.fD, e.fD);
    chk({tag, " FlushE"}, a.fE, e.fE);
    chk({tag, " FlushM"}, a.fM, e.fM);
    chk({tag, " McDoneE"}, a.done, e.done);
  endtask

  task automatic do_cycle();
    exp_t e4, e2;
    int p4, p2;
    @(negedge clk);
    a4.fa = if4.ForwardAE; a4.fb = if4.ForwardBE; a4.sF = if4.StallF; a4.sD = if4.StallD;
    a4.sE = if4.StallE; a4.fD = if4.FlushD; a4.fE = if4.FlushE; a4.fM = if4.FlushM; a4.done = if4.McDoneE;
    a2.fa = if2.ForwardAE; a2.fb = if2.ForwardBE; a2.sF = if2.StallF; a2.sD = if2.StallD;
    a2.sE = if2.StallE; a2.fD = if2.FlushD; a2.fE = if2.FlushE; a2.fM = if2.FlushM; a2.done = if2.McDoneE;
    ac4[0] = if4.LwStallCnt; ac4[1] = if4.McStallCnt; ac4[2] = if4.FlushCnt;
    ac2[0] = if2.LwStallCnt; ac2[1] = if2.McStallCnt; ac2[2] = if2.FlushCnt;
    e4 = model(4, pos4, p4);
    e2 = model(2, pos2, p2);
    if (!reset) begin
      cmpExp("mc4", a4, e4);
      cmpExp("mc2", a2, e2);
      chk("mc4 LwStallCnt", ac4[0], cntExp(cnt4[0]));
      chk("mc4 McStallCnt", ac4[1], cntExp(cnt4[1]));
      chk("mc4 FlushCnt",   ac4[2], cntExp(cnt4[2]));
      chk("mc2 LwStallCnt", ac2[0], cntExp(cnt2[0]));
      chk("mc2 McStallCnt", ac2[1], cntExp(cnt2[1]));
      chk("mc2 FlushCnt",   ac2[2], cntExp(cnt2[2]));
    end
    @(posedge clk);
    if (reset) begin
      pos4 = 0; pos2 = 0;
      for (int i = 0; i < 3; i++) begin cnt4[i] = 0; cnt2[i] = 0; end
    end else begin
      pos4 = p4; pos2 = p2;
      cnt4[0] = sat(cnt4[0] + e4.lw, 64'hFFFF_FFFF);
      cnt4[1] = sat(cnt4[1] + e4.mcs, 64'hFFFF_FFFF);
      cnt4[2] = sat(cnt4[2] + e4.fD, 64'hFFFF_FFFF);
      cnt2[0] = sat(cnt2[0] + e2.lw, 7);
      cnt2[1] = sat(cnt2[1] + e2.mcs, 7);
      cnt2[2] = sat(cnt2[2] + e2.fD, 7);
    end
    #1;
  endtask

  task automatic clearInputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    pcSrcE = 0; resultSrcE = 0; regWriteM = 0; regWriteW = 0; mcStartE = 0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    do_cycle();
    do_cycle();
    reset = 1'b0;
  endtask

  int holdLeft;

  initial begin
    // rs1D rs2D rs1E rs2E rdE rdM rdW pc ld wM wW | fa fb sF fD fE
    tbl[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) begin cnt4[i] = 0; cnt2[i] = 0; end
    doReset();

    // Reset state: idle FSM, nothing asserted, counters cleared
    do_cycle();
    chk("reset StallF", a4.sF, 0);
    chk("reset McDoneE", a4.done, 0);
    chk("reset FlushM", a4.fM, 0);
    chk("reset LwStallCnt", ac4[0], 0);

    for (int i = 0; i < 10; i++) begin
      clearInputs();
      rs1D = tbl[i].rs1D; rs2D = tbl[i].rs2D; rs1E = tbl[i].rs1E; rs2E = tbl[i].rs2E;
      rdE = tbl[i].rdE; rdM = tbl[i].rdM; rdW = tbl[i].rdW;
      pcSrcE = tbl[i].pc; resultSrcE = tbl[i].ld; regWriteM = tbl[i].wM; regWriteW = tbl[i].wW;
      do_cycle();
      chk($sformatf("vec%0d ForwardAE", i), a4.fa, tbl[i].fa);
      chk($sformatf("vec%0d ForwardBE", i), a4.fb, tbl[i].fb);
      chk($sformatf("vec%0d StallF", i), a4.sF, tbl[i].sF);
      chk($sformatf("vec%0d StallD", i), a4.sD, tbl[i].sF);
      chk($sformatf("vec%0d FlushD", i), a4.fD, tbl[i].fD);
      chk($sformatf("vec%0d FlushE", i), a4.fE, tbl[i].fE);
    end

    // Multi-cycle op held 4 cycles: one op on the 4-cycle unit, two back-to-back on the 2-cycle unit
    clearInputs();
    for (int k = 0; k < 5; k++) begin
      mcStartE = (k < 4);
      do_cycle();
      chk($sformatf("seqA mc4 StallF c%0d", k + 1), a4.sF, st4[k]);
      chk($sformatf("seqA mc4 StallE c%0d", k + 1), a4.sE, st4[k]);
      chk($sformatf("seqA mc4 FlushM c%0d", k + 1), a4.fM, st4[k]);
      chk($sformatf("seqA mc4 McDoneE c%0d", k + 1), a4.done, dn4[k]);
      chk($sformatf("seqA mc2 StallD c%0d", k + 1), a2.sD, st2[k]);
      chk($sformatf("seqA mc2 McDoneE c%0d", k + 1), a2.done, dn2[k]);
    end

    // Reset in cycle 2 of a 4-cycle op
    clearInputs();
    mcStartE = 1'b1;
    do_cycle();
    chk("seqB StallE c1", a4.sE, 1);
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    mcStartE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_cycle();
      chk($sformatf("seqB StallF +%0d", k), a4.sF, 0);
      chk($sformatf("seqB StallE +%0d", k), a4.sE, 0);
      chk($sformatf("seqB McDoneE +%0d", k), a4.done, 0);
      chk($sformatf("seqB McStallCnt +%0d", k), ac4[1], 0);
    end

    // Random traffic; ops are held for whole multiples of both occupancies
    clearInputs();
    holdLeft = 0;
    for (int i = 0; i < 600; i++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      resultSrcE = ($urandom_range(0, 2) == 0);
      regWriteM = 1'($urandom_range(0, 1));
      regWriteW = 1'($urandom_range(0, 1));
      if (holdLeft > 0) begin
        mcStartE = 1'b1;
        holdLeft--;
      end else if (mcStartE) begin
        mcStartE = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        mcStartE = 1'b1;
        holdLeft = ($urandom_range(0, 1) != 0) ? 3 : 7;
      end
      pcSrcE = !mcStartE && ($urandom_range(0, 4) == 0);
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
